// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared types, frame timing constants and packing helpers
// for the adc_capture acquisition engine and its SPI shifter.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int FRAME_CYCLES  = 320;  // clocks per conversion frame
  localparam int CONVST_CYCLES = 4;    // CONVST high pulse width
  localparam int SPI_START     = 264;  // frame cycle of the first SCK bit
  localparam int SCK_DIV       = 4;    // clocks per SCK period
  localparam int WR_CYCLE      = 313;  // RAM write cycle in odd frames
  localparam int CFG_W         = 6;    // ADC config word width
  localparam int SAMPLE_W      = 12;   // ADC sample width
  localparam int CYC_W         = 9;    // frame cycle counter width

  typedef logic [CYC_W-1:0] cyc_t;

  localparam cyc_t CYC_LAST    = cyc_t'(FRAME_CYCLES - 1);
  localparam cyc_t CYC_CONVST  = cyc_t'(CONVST_CYCLES);
  // The shifter is kicked one cycle early so its registered pins show bit 0 at SPI_START.
  localparam cyc_t CYC_SPI_PRE = cyc_t'(SPI_START - 1);
  localparam cyc_t CYC_WR      = cyc_t'(WR_CYCLE);

  // Odd-frame sample in the upper half, even-frame sample in the lower half.
  function automatic logic [31:0] pack_pair(input logic [SAMPLE_W-1:0] hi,
                                            input logic [SAMPLE_W-1:0] lo);
    return {4'b0000, hi, 4'b0000, lo};
  endfunction

  // Independent modulo-2^16 add of each half.
  function automatic logic [31:0] add_halves(input logic [31:0] a, input logic [31:0] b);
    return {a[31:16] + b[31:16], a[15:0] + b[15:0]};
  endfunction

endpackage

// File: rtl/adc_capture_spi.sv
// adc_capture_spi: 12-bit SPI shifter. A start pulse latches the 6-bit config
// and, from the next cycle, runs 12 SCK periods (2 clocks low, 2 high) sending
// the config MSB first on sdi (zeros afterwards) and sampling sdo on each SCK
// rising edge. done pulses for one clock with the complete sample.
// Ports: clk, rst_n (async, active low), start, abort (clears a transfer in
// flight), cfg[5:0], sdo in; sck, sdi, sample[11:0], done out (all registered).
module adc_capture_spi
  import adc_capture_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [CFG_W-1:0]    cfg,
  input  logic                sdo,
  output logic                sck,
  output logic                sdi,
  output logic [SAMPLE_W-1:0] sample,
  output logic                done
);

  localparam logic [1:0] PH_RISE  = 2'(SCK_DIV / 2 - 1);  // closing edge raises sck
  localparam logic [1:0] PH_LAST  = 2'(SCK_DIV - 1);
  localparam logic [3:0] BIT_LAST = 4'(SAMPLE_W - 1);

  logic                active_q, active_d;
  logic [3:0]          bit_q, bit_d;
  logic [1:0]          phase_q, phase_d;
  logic [CFG_W-1:0]    cfg_q, cfg_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic                sck_q, sck_d;
  logic                sdi_q, sdi_d;
  logic                done_q, done_d;

  // Next-state logic of the bit/phase sequencer and shift registers.
  always_comb begin
    active_d = active_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    cfg_d    = cfg_q;
    shift_d  = shift_q;
    sck_d    = sck_q;
    sdi_d    = sdi_q;
    done_d   = 1'b0;
    if (abort) begin
      active_d = 1'b0;
      bit_d    = 4'd0;
      phase_d  = 2'd0;
      cfg_d    = {CFG_W{1'b0}};
      shift_d  = {SAMPLE_W{1'b0}};
      sck_d    = 1'b0;
      sdi_d    = 1'b0;
    end else if (start) begin
      active_d = 1'b1;
      bit_d    = 4'd0;
      phase_d  = 2'd0;
      sdi_d    = cfg[CFG_W-1];
      cfg_d    = {cfg[CFG_W-2:0], 1'b0};
      shift_d  = {SAMPLE_W{1'b0}};
      sck_d    = 1'b0;
    end else if (active_q) begin
      phase_d = phase_q + 2'd1;
      if (phase_q == PH_RISE) begin
        sck_d   = 1'b1;
        shift_d = {shift_q[SAMPLE_W-2:0], sdo};
      end else if (phase_q == PH_LAST) begin
        sck_d   = 1'b0;
        phase_d = 2'd0;
        if (bit_q == BIT_LAST) begin
          active_d = 1'b0;
          sdi_d    = 1'b0;
          done_d   = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          // Config shifts out MSB first; the zero fill yields sdi=0 after six bits.
          sdi_d = cfg_q[CFG_W-1];
          cfg_d = {cfg_q[CFG_W-2:0], 1'b0};
        end
      end else begin
        sck_d = sck_q;
      end
    end else begin
      active_d = 1'b0;
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      bit_q    <= 4'd0;
      phase_q  <= 2'd0;
      cfg_q    <= {CFG_W{1'b0}};
      shift_q  <= {SAMPLE_W{1'b0}};
      sck_q    <= 1'b0;
      sdi_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      cfg_q    <= cfg_d;
      shift_q  <= shift_d;
      sck_q    <= sck_d;
      sdi_q    <= sdi_d;
      done_q   <= done_d;
    end
  end

  assign sck    = sck_q;
  assign sdi    = sdi_q;
  assign sample = shift_q;
  assign done   = done_q;

endmodule

// File: rtl/adc_capture.sv
// adc_capture: free-running acquisition engine for an LTC2308-style SPI ADC.
// One conversion per 320-clock frame; even/odd frames alternate two 6-bit
// configs, and each even/odd sample pair is packed into one 32-bit RAM word.
// Ports: clk, rst_n (async, active low); ADC pins adc_convst/adc_sck/adc_sdi
// out, adc_sdo in; RAM port adc_ram_addr/adc_ram_we/adc_ram_wr_data out,
// adc_ram_rd_data in; host controls adc_config_odd/even (bits[5:0] used),
// adc_start (high = arm/abort, falling edge = run), adc_sequence_one.
// Build option: define ADC_ACCUM_EN to add the packed word to adc_ram_rd_data
// per 16-bit half (averaging over repeated passes); otherwise rd_data is unused.
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              adc_convst,
  output logic              adc_sck,
  output logic              adc_sdi,
  input  logic              adc_sdo,
  output logic [ADDR_W-1:0] adc_ram_addr,
  input  logic [31:0]       adc_ram_rd_data,
  output logic              adc_ram_we,
  output logic [31:0]       adc_ram_wr_data,
  input  logic [31:0]       adc_config_odd,
  input  logic [31:0]       adc_config_even,
  input  logic              adc_start,
  input  logic              adc_sequence_one
);

  state_e              state_q, state_d;
  cyc_t                cyc_q, cyc_d;
  logic                odd_q, odd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                seq_one_q, seq_one_d;
  logic [SAMPLE_W-1:0] even_q, even_d;
  logic                convst_q, convst_d;
  logic                we_q, we_d;
  logic [31:0]         wr_data_q, wr_data_d;

  logic                spi_start_s, spi_abort_s, spi_done_s;
  logic                spi_sck_s, spi_sdi_s;
  logic [SAMPLE_W-1:0] spi_sample_s;
  logic [CFG_W-1:0]    cfg_s;
  logic [31:0]         packed_s, merged_s;
  logic                unused_s;

  // The ADC applies a config to the following conversion, so each frame sends the other parity's word.
  assign cfg_s    = odd_q ? adc_config_even[CFG_W-1:0] : adc_config_odd[CFG_W-1:0];
  assign packed_s = pack_pair(spi_sample_s, even_q);
`ifdef ADC_ACCUM_EN
  assign merged_s = add_halves(adc_ram_rd_data, packed_s);
  assign unused_s = ^{adc_config_odd[31:CFG_W], adc_config_even[31:CFG_W]};
`else
  assign merged_s = packed_s;
  assign unused_s = ^{adc_config_odd[31:CFG_W], adc_config_even[31:CFG_W], adc_ram_rd_data};
`endif

  // Sequencer: IDLE/ARMED/RUN, frame cycle counter, parity, address and write strobe.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    odd_d       = odd_q;
    addr_d      = addr_q;
    seq_one_d   = seq_one_q;
    even_d      = even_q;
    we_d        = 1'b0;
    wr_data_d   = 32'h0000_0000;
    spi_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cyc_d  = cyc_t'(0);
        odd_d  = 1'b0;
        addr_d = {ADDR_W{1'b0}};
        if (adc_start) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        cyc_d     = cyc_t'(0);
        odd_d     = 1'b0;
        addr_d    = {ADDR_W{1'b0}};
        even_d    = {SAMPLE_W{1'b0}};
        seq_one_d = adc_sequence_one;
        if (!adc_start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_RUN: begin
        if (adc_start) begin
          // Abort: anything gathered in the current frame pair is dropped.
          state_d = ST_ARMED;
          cyc_d   = cyc_t'(0);
          odd_d   = 1'b0;
          addr_d  = {ADDR_W{1'b0}};
        end else begin
          if (cyc_q == CYC_LAST) begin
            cyc_d = cyc_t'(0);
            odd_d = ~odd_q;
          end else begin
            cyc_d = cyc_q + cyc_t'(1);
          end
          spi_start_s = (cyc_q == CYC_SPI_PRE);
          if (spi_done_s) begin
            if (odd_q) begin
              we_d      = 1'b1;
              wr_data_d = merged_s;
            end else begin
              even_d = spi_sample_s;
            end
          end else begin
            even_d = even_q;
          end
          // The write is visible at CYC_WR; the address moves on one cycle later.
          if ((cyc_q == CYC_WR) && odd_q) begin
            if ((addr_q == {ADDR_W{1'b1}}) && seq_one_q) begin
              state_d = ST_IDLE;
              addr_d  = {ADDR_W{1'b0}};
              cyc_d   = cyc_t'(0);
              odd_d   = 1'b0;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end else begin
            addr_d = addr_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = cyc_t'(0);
        odd_d   = 1'b0;
        addr_d  = {ADDR_W{1'b0}};
      end
    endcase
    convst_d    = (state_d == ST_RUN) && (cyc_d < CYC_CONVST);
    spi_abort_s = (state_d != ST_RUN);
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cyc_q     <= cyc_t'(0);
      odd_q     <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      seq_one_q <= 1'b0;
      even_q    <= {SAMPLE_W{1'b0}};
      convst_q  <= 1'b0;
      we_q      <= 1'b0;
      wr_data_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      odd_q     <= odd_d;
      addr_q    <= addr_d;
      seq_one_q <= seq_one_d;
      even_q    <= even_d;
      convst_q  <= convst_d;
      we_q      <= we_d;
      wr_data_q <= wr_data_d;
    end
  end

  adc_capture_spi u_spi (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (spi_start_s),
    .abort  (spi_abort_s),
    .cfg    (cfg_s),
    .sdo    (adc_sdo),
    .sck    (spi_sck_s),
    .sdi    (spi_sdi_s),
    .sample (spi_sample_s),
    .done   (spi_done_s)
  );

  assign adc_convst      = convst_q;
  assign adc_sck         = spi_sck_s;
  assign adc_sdi         = spi_sdi_s;
  assign adc_ram_addr    = addr_q;
  assign adc_ram_we      = we_q;
  assign adc_ram_wr_data = wr_data_q;

endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: directed bench for adc_capture, built with a 3-bit RAM
// address so ring wrap and single-pass end are reached quickly.
module tb_adc_capture;

  localparam int AW = 3;
  localparam logic [31:0] RD_CONST = 32'h0001_0002;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          adc_convst, adc_sck, adc_sdi, adc_sdo;
  logic [AW-1:0] adc_ram_addr;
  logic [31:0]   adc_ram_rd_data;
  logic          adc_ram_we;
  logic [31:0]   adc_ram_wr_data;
  logic [31:0]   adc_config_odd, adc_config_even;
  logic          adc_start, adc_sequence_one;

  int n_checks = 0;
  int n_pass   = 0;

  adc_capture #(.ADDR_W(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .adc_convst      (adc_convst),
    .adc_sck         (adc_sck),
    .adc_sdi         (adc_sdi),
    .adc_sdo         (adc_sdo),
    .adc_ram_addr    (adc_ram_addr),
    .adc_ram_rd_data (adc_ram_rd_data),
    .adc_ram_we      (adc_ram_we),
    .adc_ram_wr_data (adc_ram_wr_data),
    .adc_config_odd  (adc_config_odd),
    .adc_config_even (adc_config_even),
    .adc_start       (adc_start),
    .adc_sequence_one(adc_sequence_one)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_word(input logic [11:0] hi, input logic [11:0] lo);
    logic [31:0] w;
    logic [31:0] r;
    w = {4'h0, hi, 4'h0, lo};
    r = RD_CONST;
`ifdef ADC_ACCUM_EN
    w = {w[31:16] + r[31:16], w[15:0] + r[15:0]};
`else
    r = 32'h0;
    w = w | r;
`endif
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs ncyc cycles of a frame starting at c=0, driving sdo from pat and
  // comparing pin behaviour against the frame timing.
  task automatic run_frame(input string tag, input int ncyc, input logic [11:0] pat,
                           input logic [5:0] cfg, input logic exp_we,
                           input logic [31:0] exp_data, input int exp_addr,
                           input int exp_addr_end);
    int conv_err = 0, sck_err = 0, sdi_err = 0, we_cnt = 0, we_c = -1;
    logic [11:0] sdi_bits = 12'h000;
    logic [31:0] we_data = 32'h0;
    logic [31:0] we_addr = 32'h0;
    for (int c = 0; c < ncyc; c++) begin
      logic in_spi, e_conv, e_sck, e_sdi;
      int k, p;
      tick();
      in_spi = (c >= 264) && (c < 312);
      k = in_spi ? (c - 264) / 4 : 0;
      p = in_spi ? (c - 264) % 4 : 0;
      e_conv = (c < 4);
      e_sck  = in_spi && (p >= 2);
      e_sdi  = (in_spi && (k < 6)) ? cfg[5-k] : 1'b0;
      if (adc_convst !== e_conv) conv_err++;
      if (adc_sck !== e_sck) sck_err++;
      if (adc_sdi !== e_sdi) sdi_err++;
      if (in_spi && (p == 2)) sdi_bits[11-k] = adc_sdi;
      if (adc_ram_we === 1'b1) begin
        we_cnt++;
        we_c    = c;
        we_data = adc_ram_wr_data;
        we_addr = {29'b0, adc_ram_addr};
      end
      adc_sdo = in_spi ? pat[11-k] : 1'b0;
    end
    chk($sformatf("%s_convst_errs", tag), conv_err, 0);
    chk($sformatf("%s_sck_errs", tag), sck_err, 0);
    chk($sformatf("%s_sdi_errs", tag), sdi_err, 0);
    chk($sformatf("%s_we_count", tag), we_cnt, {31'b0, exp_we});
    if (exp_we) begin
      chk($sformatf("%s_we_cycle", tag), we_c, 313);
      chk($sformatf("%s_wr_data", tag), we_data, exp_data);
      chk($sformatf("%s_wr_addr", tag), we_addr, exp_addr);
    end
    if (ncyc == 320) begin
      chk($sformatf("%s_sdi_bits", tag), {20'b0, sdi_bits}, {20'b0, cfg, 6'b000000});
      chk($sformatf("%s_addr_end", tag), {29'b0, adc_ram_addr}, exp_addr_end);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_convst"}, {31'b0, adc_convst}, 32'h0);
    chk({tag, "_sck"}, {31'b0, adc_sck}, 32'h0);
    chk({tag, "_sdi"}, {31'b0, adc_sdi}, 32'h0);
    chk({tag, "_we"}, {31'b0, adc_ram_we}, 32'h0);
    chk({tag, "_addr"}, {29'b0, adc_ram_addr}, 32'h0);
    chk({tag, "_wr_data"}, adc_ram_wr_data, 32'h0);
  endtask

  initial begin
    logic [11:0] lo, hi;
    logic [5:0]  co, ce;
    int act;
    rst_n = 1'b0; adc_start = 1'b0; adc_sequence_one = 1'b0; adc_sdo = 1'b0;
    adc_config_odd = 32'h0; adc_config_even = 32'h0; adc_ram_rd_data = RD_CONST;
    #23;
    chk_quiet("reset");
    rst_n = 1'b1;
    repeat (5) tick();
    chk_quiet("idle");

    // Basic acquisition; reserved config bits set to show they are ignored.
    adc_config_even = 32'hABCD_EF15;
    adc_config_odd  = 32'hFFFF_FFEA;
    adc_start = 1'b1;
    repeat (13) tick();
    chk_quiet("armed");
    adc_start = 1'b0;
    run_frame("f0", 320, 12'hFFF, 6'b101010, 1'b0, 32'h0, 0, 0);
`ifdef ADC_ACCUM_EN
    run_frame("f1", 320, 12'hFFF, 6'b010101, 1'b1, 32'h1000_1001, 0, 1);
`else
    run_frame("f1", 320, 12'hFFF, 6'b010101, 1'b1, 32'h0FFF_0FFF, 0, 1);
`endif
    run_frame("f2", 320, 12'hA5C, 6'b101010, 1'b0, 32'h0, 0, 1);
    run_frame("f3", 320, 12'h3F0, 6'b010101, 1'b1, exp_word(12'h3F0, 12'hA5C), 1, 2);

    // Continuous ring: fill to the top address and wrap to 0.
    for (int a = 2; a < 9; a++) begin
      lo = 12'(a * 12'h123);
      hi = 12'(12'hFFF - a * 12'h111);
      co = 6'(a * 7);
      ce = 6'(a * 5 + 1);
      adc_config_odd  = {26'h2AAAAAA, co};
      adc_config_even = {26'h1555555, ce};
      run_frame($sformatf("ring%0d_e", a), 320, lo, co, 1'b0, 32'h0, a % 8, a % 8);
      run_frame($sformatf("ring%0d_o", a), 320, hi, ce, 1'b1, exp_word(hi, lo), a % 8, (a + 1) % 8);
    end

    // Abort in the odd frame at c=280, then restart from frame 0.
    adc_config_even = 32'h0000_0002;
    adc_config_odd  = 32'h0000_0033;
    run_frame("ab_e", 320, 12'h111, 6'h33, 1'b0, 32'h0, 1, 1);
    run_frame("ab_o", 281, 12'h222, 6'h02, 1'b0, 32'h0, 1, 1);
    adc_start = 1'b1;
    tick();
    chk_quiet("abort");
    act = 0;
    repeat (5) begin
      tick();
      if (adc_ram_we === 1'b1) act++;
    end
    chk("abort_no_write", act, 0);
    adc_start = 1'b0;
    run_frame("post_e", 320, 12'h456, 6'h33, 1'b0, 32'h0, 0, 0);
    run_frame("post_o", 320, 12'h789, 6'h02, 1'b1, exp_word(12'h789, 12'h456), 0, 1);

    // Single pass: mode is latched in ARMED, so dropping the input later has no effect.
    adc_start = 1'b1;
    adc_sequence_one = 1'b1;
    repeat (3) tick();
    adc_start = 1'b0;
    for (int a = 0; a < 8; a++) begin
      lo = 12'(12'h0F0 + a);
      hi = 12'(12'hC00 - a);
      run_frame($sformatf("one%0d_e", a), 320, lo, 6'h33, 1'b0, 32'h0, a, a);
      adc_sequence_one = 1'b0;
      run_frame($sformatf("one%0d_o", a), 320, hi, 6'h02, 1'b1, exp_word(hi, lo), a, (a == 7) ? 0 : a + 1);
    end
    act = 0;
    repeat (400) begin
      tick();
      if ((adc_convst | adc_sck | adc_sdi | adc_ram_we) === 1'b1) act++;
    end
    chk("single_idle_activity", act, 0);
    chk("single_idle_addr", {29'b0, adc_ram_addr}, 32'h0);

    // Asynchronous reset in the middle of the SPI transfer.
    adc_start = 1'b1;
    repeat (2) tick();
    adc_start = 1'b0;
    run_frame("rs", 291, 12'hABC, 6'h33, 1'b0, 32'h0, 0, 0);
    chk("rs_sck_high", {31'b0, adc_sck}, 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_quiet("async_reset");
    #3 rst_n = 1'b1;
    act = 0;
    repeat (330) begin
      tick();
      if ((adc_convst | adc_sck | adc_sdi | adc_ram_we) === 1'b1) act++;
    end
    chk("post_reset_activity", act, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
